pipe_hazard: RTL

PIPE_HAZARD -- requirements
Module: pipe_hazard

---
 rtl/pipe_hazard_pkg.sv | 33 +++
 rtl/pipe_hazard_srcchk.sv | 51 +++++
 rtl/pipe_hazard.sv | 113 +++++++++++
 3 files changed

// File: rtl/pipe_hazard_pkg.sv
// Shared types and constants for the pipe_hazard interlock / forwarding unit.
package pipe_hazard_pkg;

    localparam int REG_IDX_W = 5;

    // Forward-select encodings: 0 reads the register file, k takes stage k's result.
    localparam int SEL_RF = 0;
    localparam int SEL_X  = 1;
    localparam int SEL_M  = 2;
    localparam int SEL_WB = 3;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] rd;
        logic                 regwren;
        logic                 memren;
    } shadow_entry_t;

    function automatic shadow_entry_t make_entry(
        input logic                 valid,
        input logic [REG_IDX_W-1:0] rd,
        input logic                 regwren,
        input logic                 memren
    );
        shadow_entry_t e;
        e.valid   = valid;
        e.rd      = rd;
        e.regwren = regwren;
        e.memren  = memren;
        return e;
    endfunction

endpackage

// File: rtl/pipe_hazard_srcchk.sv
// Per-source hazard check: finds the youngest in-flight writer of one source
// register and decides between stalling and forwarding from that stage.
module pipe_hazard_srcchk
    import pipe_hazard_pkg::*;
#(
    parameter int NSTAGE     = 3,
    parameter int LOAD_READY = 2,
    parameter int SEL_W      = $clog2(NSTAGE + 1),
    parameter bit FWD_EN     = 1'b0
) (
    input  logic                        use_i,
    input  logic [REG_IDX_W-1:0]        idx_i,
    input  shadow_entry_t [NSTAGE:1]    entries_i,
    output logic                        stall_o,
    output logic [SEL_W-1:0]            sel_o
);

    logic hit;
    logic hit_load;
    int   hit_k;

    // Scan oldest to youngest so the lowest matching stage is what remains.
    always_comb begin
        hit      = 1'b0;
        hit_load = 1'b0;
        hit_k    = 0;
        for (int k = NSTAGE; k >= 1; k--) begin
            if (use_i && (idx_i != '0) && entries_i[k].valid &&
                entries_i[k].regwren && (entries_i[k].rd == idx_i)) begin
                hit      = 1'b1;
                hit_load = entries_i[k].memren;
                hit_k    = k;
            end
        end
    end

    always_comb begin
        stall_o = 1'b0;
        sel_o   = SEL_W'(SEL_RF);
        if (FWD_EN) begin
            stall_o = hit && hit_load && (hit_k < LOAD_READY);
            if (hit && !stall_o) begin
                sel_o = SEL_W'(hit_k);
            end
        end else begin
            // The oldest stage is covered by the register-file write-through.
            stall_o = hit && (hit_k < NSTAGE);
        end
    end

endmodule

// File: rtl/pipe_hazard.sv
// Pipeline hazard unit: shadow of post-decode stages, stall/flush/forward
// decisions and saturating event counters. Forwarding enabled by PIPE_HAZARD_FORWARD_EN.
module pipe_hazard
    import pipe_hazard_pkg::*;
#(
    parameter int NSTAGE     = 3,
    parameter int LOAD_READY = 2,
    parameter int CNT_W      = 32,
    parameter int SEL_W      = $clog2(NSTAGE + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid_i,
    input  logic [4:0]           id_rs1_i,
    input  logic [4:0]           id_rs2_i,
    input  logic                 id_rs1_use_i,
    input  logic                 id_rs2_use_i,
    input  logic [4:0]           id_rd_i,
    input  logic                 id_regwren_i,
    input  logic                 id_memren_i,
    input  logic                 ex_redirect_i,
    output logic                 stall_o,
    output logic                 flush_o,
    output logic [SEL_W-1:0]     fwd_rs1_sel_o,
    output logic [SEL_W-1:0]     fwd_rs2_sel_o,
    output logic [CNT_W-1:0]     stall_cnt_o,
    output logic [CNT_W-1:0]     flush_cnt_o
);

`ifdef PIPE_HAZARD_FORWARD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    shadow_entry_t [NSTAGE:1] shadow_q, shadow_d;
    logic [CNT_W-1:0]         stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]         flush_cnt_q, flush_cnt_d;

    logic active;
    logic rs1_stall, rs2_stall;

    // Outputs are forced quiet while reset is held, independent of any clock edge.
    assign active = id_valid_i & ~reset;

    pipe_hazard_srcchk #(
        .NSTAGE     (NSTAGE),
        .LOAD_READY (LOAD_READY),
        .SEL_W      (SEL_W),
        .FWD_EN     (FWD_EN)
    ) u_rs1_chk (
        .use_i     (id_rs1_use_i & active),
        .idx_i     (id_rs1_i),
        .entries_i (shadow_q),
        .stall_o   (rs1_stall),
        .sel_o     (fwd_rs1_sel_o)
    );

    pipe_hazard_srcchk #(
        .NSTAGE     (NSTAGE),
        .LOAD_READY (LOAD_READY),
        .SEL_W      (SEL_W),
        .FWD_EN     (FWD_EN)
    ) u_rs2_chk (
        .use_i     (id_rs2_use_i & active),
        .idx_i     (id_rs2_i),
        .entries_i (shadow_q),
        .stall_o   (rs2_stall),
        .sel_o     (fwd_rs2_sel_o)
    );

    // A redirect squashes the dependent instruction, so it overrides any stall.
    assign flush_o = ex_redirect_i & ~reset;
    assign stall_o = (rs1_stall | rs2_stall) & ~flush_o;

    always_comb begin
        shadow_d    = shadow_q;
        shadow_d[1] = make_entry(1'b0, '0, 1'b0, 1'b0);
        if (id_valid_i && !stall_o && !flush_o) begin
            shadow_d[1] = make_entry(1'b1, id_rd_i, id_regwren_i, id_memren_i);
        end
        for (int k = 2; k <= NSTAGE; k++) begin
            shadow_d[k] = shadow_q[k-1];
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_o && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q    <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            shadow_q    <= shadow_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule
